// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// Fetch FSM encoding and instruction field positions live here.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int JIDX_MSB = 25;
    localparam int JIDX_LSB = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        ERROR = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] branch_offset(
        input logic [INSTR_W-1:0] ins
    );
        return {{14{ins[IMM_MSB]}}, ins[IMM_MSB:IMM_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC selection for a retiring instruction.
// Jump wins over a taken branch; otherwise fall through to pc+4.
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0]        pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               jump,
    input  logic               pcsrc,
    output logic [31:0]        next_pc
);

    logic [31:0] jump_tgt;
    logic [31:0] br_tgt;
    logic        unused_op;

    assign jump_tgt = {pc_plus4[31:28],
                       instr[JIDX_MSB:JIDX_LSB],
                       2'b00};

    assign br_tgt = pc_plus4 + branch_offset(instr);

    // Opcode decode belongs to the control unit.
    assign unused_op = ^instr[OP_MSB:OP_LSB];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_tgt;
        end else if (pcsrc) begin
            next_pc = br_tgt;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, fetches over req/ack,
// holds each word until the datapath retires it.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        pcsrc,
    output logic        fetch_err
);

    localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    fetch_state_t        state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [31:0]         next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_logic u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .jump     (jump),
        .pcsrc    (pcsrc),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    wait_cnt_d = '0;
                    state_d    = ISSUE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == CNT_LAST) begin
                        state_d = ERROR;
                    end
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RST_PC;
            instr_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs are forced idle while reset is held, not just after it.
    assign imem_req    = !rst && (state_q == FETCH);
    assign instr_valid = !rst && (state_q == ISSUE);
    assign fetch_err   = !rst && (state_q == ERROR);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table,
// multi-cycle corner sequences and a randomized reference model.
module tb_instr_fetch_unit;

    localparam int WL = 16;

    logic        clk = 1'b0;
    logic        rst, imem_ack, instr_ready, jump, pcsrc;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic        req_b, valid_b, err_b;
    logic [31:0] addr_b, instr_b, pc_b, pcp4_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.WAIT_LIMIT(WL)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump(jump), .pcsrc(pcsrc), .fetch_err(fetch_err)
    );

    instr_fetch_unit #(
        .RESET_PC(32'h4000_0003), .WAIT_LIMIT(WL)
    ) u_dut_hi (
        .clk(clk), .rst(rst),
        .imem_req(req_b), .imem_addr(addr_b),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(instr_b), .pc(pc_b), .pc_plus4(pcp4_b),
        .instr_valid(valid_b), .instr_ready(instr_ready),
        .jump(jump), .pcsrc(pcsrc), .fetch_err(err_b)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        j;
        logic        b;
        logic [31:0] cur_pc;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] p,
                                             input logic [31:0] ins,
                                             input logic j,
                                             input logic b);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b) return p4 + 32'(int'($signed(ins[15:0])) * 4);
        return p4;
    endfunction

    // Reference state: what the IR holds and whether memory timed out.
    logic [31:0] m_pc, m_instr;
    logic        m_have, m_err;
    int          m_miss;

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; jump = 1'b0; pcsrc = 1'b0;

        // Reset held for two cycles
        tick();
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        tick();
        chk("rst_pc", pc, 0);
        chk("rst_err", fetch_err, 0);
        rst = 1'b0;
        #1;
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 0);
        chk("rel_instr", instr, 0);
        chk("rel_valid", instr_valid, 0);
        chk("hi_rst_pc", pc_b, 32'h4000_0000);

        tbl[0] = '{32'h2008_0005, 0, 0, 32'h0000_0000, 32'h0000_0004};
        tbl[1] = '{32'h0800_0004, 1, 0, 32'h0000_0004, 32'h0000_0010};
        tbl[2] = '{32'h1000_FFFE, 0, 1, 32'h0000_0010, 32'h0000_000C};
        tbl[3] = '{32'h1000_FFFB, 0, 1, 32'h0000_000C, 32'hFFFF_FFFC};
        tbl[4] = '{32'h1000_0001, 0, 1, 32'hFFFF_FFFC, 32'h0000_0004};
        tbl[5] = '{32'h1000_0003, 0, 0, 32'h0000_0004, 32'h0000_0008};
        tbl[6] = '{32'h0800_0010, 1, 1, 32'h0000_0008, 32'h0000_0040};

        foreach (tbl[i]) begin
            chk($sformatf("t%0d_req", i), imem_req, 1);
            chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].cur_pc);
            imem_ack = 1'b1;
            imem_rdata = tbl[i].rdata;
            tick();
            imem_ack = 1'b0;
            chk($sformatf("t%0d_valid", i), instr_valid, 1);
            chk($sformatf("t%0d_noreq", i), imem_req, 0);
            chk($sformatf("t%0d_instr", i), instr, tbl[i].rdata);
            chk($sformatf("t%0d_pc", i), pc, tbl[i].cur_pc);
            chk($sformatf("t%0d_pc4", i), pc_plus4, tbl[i].cur_pc + 32'd4);
            instr_ready = 1'b1;
            jump = tbl[i].j;
            pcsrc = tbl[i].b;
            tick();
            instr_ready = 1'b0; jump = 1'b0; pcsrc = 1'b0;
            chk($sformatf("t%0d_nreq", i), imem_req, 1);
            chk($sformatf("t%0d_nvalid", i), instr_valid, 0);
            chk($sformatf("t%0d_naddr", i), imem_addr, tbl[i].nxt);
        end

        // Jump beats branch in the 0x4000_0000 region
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("hi_addr0", addr_b, 32'h4000_0000);
        imem_ack = 1'b1;
        imem_rdata = 32'h0800_0010;
        tick();
        imem_ack = 1'b0;
        instr_ready = 1'b1; jump = 1'b1; pcsrc = 1'b1;
        tick();
        instr_ready = 1'b0; jump = 1'b0; pcsrc = 1'b0;
        chk("hi_jaddr", addr_b, 32'h4000_0040);
        chk("lo_jaddr", imem_addr, 32'h0000_0040);

        // Stall with jump toggling
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'b0;
            jump = i[0];
            pcsrc = 1'b1;
            tick();
            chk("stall_instr", instr, 32'h1234_5678);
            chk("stall_pc", pc, 32'h0000_0040);
            chk("stall_req", imem_req, 0);
            chk("stall_valid", instr_valid, 1);
        end
        instr_ready = 1'b1; jump = 1'b0; pcsrc = 1'b0;
        tick();
        instr_ready = 1'b0;
        chk("stall_next", imem_addr, 32'h0000_0044);

        // Memory timeout, ignored ack, reset with ack high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < WL - 1; i++) begin
            tick();
            chk("to_noerr", fetch_err, 0);
            chk("to_req", imem_req, 1);
        end
        tick();
        chk("to_err", fetch_err, 1);
        chk("to_req0", imem_req, 0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_sticky", fetch_err, 1);
            chk("err_valid", instr_valid, 0);
            chk("err_req", imem_req, 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("clr_err", fetch_err, 0);
        chk("clr_pc", pc, 0);
        chk("clr_instr", instr, 0);
        chk("clr_valid", instr_valid, 0);
        chk("clr_req", imem_req, 1);

        // Randomized run against the reference model
        m_pc = 0; m_instr = 0; m_have = 0; m_err = 0; m_miss = 0;
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 149) == 0);
            imem_ack    = ($urandom_range(0, 3) != 0);
            imem_rdata  = $urandom;
            instr_ready = $urandom_range(0, 1) == 1;
            jump        = $urandom_range(0, 3) == 0;
            pcsrc       = $urandom_range(0, 2) == 0;
            if (c >= 2000 && c < 2040) imem_ack = 1'b0;
            #1;
            chk("r_req", imem_req, !rst && !m_err && !m_have);
            chk("r_valid", instr_valid, !rst && !m_err && m_have);
            chk("r_err", fetch_err, !rst && m_err);
            chk("r_pc", pc, m_pc);
            chk("r_addr", imem_addr, m_pc);
            chk("r_pc4", pc_plus4, m_pc + 32'd4);
            chk("r_instr", instr, m_instr);
            if (rst) begin
                m_pc = 0; m_instr = 0; m_have = 0; m_err = 0; m_miss = 0;
            end else if (m_err) begin
                m_err = 1;
            end else if (!m_have) begin
                if (imem_ack) begin
                    m_instr = imem_rdata;
                    m_have = 1;
                    m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss == WL) m_err = 1;
                end
            end else if (instr_ready) begin
                m_pc = ref_next(m_pc, m_instr, jump, pcsrc);
                m_have = 0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
